// File: rtl/bec_key_sequencer_if.sv
// bec_key_sequencer_if: control, key and bit-stream signals between a driver and the key sequencer
interface bec_key_sequencer_if #(
    parameter int KEY_W = 163,
    parameter int CNT_W = 8
);
    logic             load;
    logic [KEY_W-1:0] key_in;
    logic             start;
    logic             abort;
    logic             step_req;
    logic             ki;
    logic             ki_valid;
    logic             last_bit;
    logic [CNT_W-1:0] bit_idx;
    logic             busy;
    logic             done;
    logic             zero_key;
    modport master (
        output load, key_in, start, abort, step_req,
        input  ki, ki_valid, last_bit, bit_idx, busy, done, zero_key
    );
    modport slave (
        input  load, key_in, start, abort, step_req,
        output ki, ki_valid, last_bit, bit_idx, busy, done, zero_key
    );
endinterface

// File: rtl/bec_key_sequencer.sv
// bec_key_sequencer: MSB-first scalar bit feeder for the ladder core; BEC_KEY_SKIP_LZ_EN enables leading-zero skipping
module bec_key_sequencer #(
    parameter int KEY_W = 163,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    bec_key_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOADED, SCAN, ISSUE, DONE} state_t;
    localparam logic [CNT_W-1:0] KEY_N = CNT_W'(KEY_W);
    state_t           state, nxt_state;
    logic [KEY_W-1:0] key_sr, nxt_key;
    logic [CNT_W-1:0] remaining, nxt_rem, rem_dec;
    logic             zero_r, nxt_zero;
    assign rem_dec = (remaining != '0) ? remaining - 1'b1 : remaining;
    assign bus.zero_key = zero_r;
    // next-state, key shift and counter decisions; abort overrides everything
    always_comb begin
        nxt_state = state;
        nxt_key   = key_sr;
        nxt_rem   = remaining;
        nxt_zero  = zero_r;
        if (bus.abort) begin
            nxt_state = IDLE;
            nxt_key   = '0;
            nxt_rem   = '0;
        end else begin
            case (state)
                IDLE, LOADED: begin
                    if (bus.load) begin
                        nxt_key   = bus.key_in;
                        nxt_rem   = KEY_N;
                        nxt_zero  = 1'b0;
                        nxt_state = LOADED;
                    end else if (state == LOADED && bus.start) begin
`ifdef BEC_KEY_SKIP_LZ_EN
                        nxt_state = SCAN;
`else
                        nxt_state = ISSUE;
`endif
                    end
                end
`ifdef BEC_KEY_SKIP_LZ_EN
                SCAN: begin
                    if (key_sr[KEY_W-1]) begin
                        nxt_state = ISSUE;
                    end else begin
                        nxt_key = {key_sr[KEY_W-2:0], 1'b0};
                        nxt_rem = rem_dec;
                        if (remaining <= 1) begin
                            nxt_zero  = 1'b1;
                            nxt_state = DONE;
                        end else if (key_sr[KEY_W-2]) begin
                            nxt_state = ISSUE;
                        end
                    end
                end
`endif
                ISSUE: begin
                    if (bus.step_req) begin
                        nxt_key = {key_sr[KEY_W-2:0], 1'b0};
                        nxt_rem = rem_dec;
                        if (remaining <= 1)
                            nxt_state = DONE;
                    end
                end
                DONE: begin
                    nxt_key   = '0;
                    nxt_state = IDLE;
                end
                default: nxt_state = IDLE;
            endcase
        end
    end
    // state registers and outputs registered from the next-state values
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            key_sr       <= '0;
            remaining    <= '0;
            zero_r       <= 1'b0;
            bus.ki       <= 1'b0;
            bus.ki_valid <= 1'b0;
            bus.last_bit <= 1'b0;
            bus.bit_idx  <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
        end else begin
            state        <= nxt_state;
            key_sr       <= nxt_key;
            remaining    <= nxt_rem;
            zero_r       <= nxt_zero;
            bus.ki       <= (nxt_state == ISSUE) && nxt_key[KEY_W-1];
            bus.ki_valid <= nxt_state == ISSUE;
            bus.last_bit <= (nxt_state == ISSUE) && (nxt_rem == 1);
            bus.bit_idx  <= (nxt_state == ISSUE) ? nxt_rem - 1'b1 : '0;
            bus.busy     <= (nxt_state == SCAN) || (nxt_state == ISSUE);
            bus.done     <= nxt_state == DONE;
        end
    end
endmodule

// File: tb/tb_bec_key_sequencer.sv
// tb_bec_key_sequencer: directed checks of bit order, timing, backpressure, abort and ignored inputs
module tb_bec_key_sequencer;
    localparam int KEY_W = 163;
    localparam int CNT_W = 8;
`ifdef BEC_KEY_SKIP_LZ_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [KEY_W-1:0] key_a, key_one, key_zero, key_ones, key_bp, key_top;
    bec_key_sequencer_if #(.KEY_W(KEY_W), .CNT_W(CNT_W)) bus ();
    bec_key_sequencer #(.KEY_W(KEY_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic start_key(input logic [KEY_W-1:0] k);
        bus.key_in = k;
        bus.load   = 1'b1;
        tick;
        bus.load  = 1'b0;
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
    endtask
    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.ki_valid && n < 300) begin
            tick;
            n++;
        end
        check({tag, "_valid"}, bus.ki_valid, 1);
    endtask
    task automatic run_full(input string tag, input logic [KEY_W-1:0] k, input int first,
                            input int nbits, input int exp_done, input int load_at);
        int idx  = first;
        int bits = 0;
        int cyc  = 1;
        start_key(k);
        bus.step_req = 1'b1;
        while (!bus.done && cyc < 600) begin
            if (bus.ki_valid) begin
                if (idx >= 0) begin
                    check({tag, "_ki"}, bus.ki, k[idx]);
                    check({tag, "_idx"}, bus.bit_idx, idx);
                    check({tag, "_last"}, bus.last_bit, idx == 0);
                end else begin
                    check({tag, "_extra_bit"}, 1, 0);
                end
                idx--;
                bits++;
            end
            bus.load   = (cyc == load_at);
            bus.key_in = ~k;
            tick;
            cyc++;
        end
        bus.step_req = 1'b0;
        bus.load     = 1'b0;
        check({tag, "_done_cycle"}, cyc, exp_done);
        check({tag, "_bits"}, bits, nbits);
        check({tag, "_valid_at_done"}, bus.ki_valid, 0);
        check({tag, "_zero_key"}, bus.zero_key, LZ && (k == '0));
        tick;
        check({tag, "_done_pulse"}, bus.done, 0);
        check({tag, "_idle"}, bus.busy, 0);
    endtask
    initial begin
        int gaps [3];
        logic exp_bits [3];
        int n;
        gaps     = '{0, 3, 7};
        exp_bits = '{1'b1, 1'b0, 1'b1};
        key_a    = {3'b110, 128'hDEADBEEF_01234567_89ABCDEF_F0E1D2C3, 32'h8000_0001};
        key_one  = '0;
        key_one[0] = 1'b1;
        key_zero = '0;
        key_ones = '1;
        key_top  = '0;
        key_top[KEY_W-1] = 1'b1;
        key_bp   = LZ ? {160'h0, 3'b101} : {3'b101, 160'h0};
        bus.load = 0; bus.start = 0; bus.abort = 0; bus.step_req = 0; bus.key_in = '0;
        tick;
        tick;
        rst = 1'b0;
        check("rst_ki", bus.ki, 0);
        check("rst_valid", bus.ki_valid, 0);
        check("rst_last", bus.last_bit, 0);
        check("rst_idx", bus.bit_idx, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_zero", bus.zero_key, 0);
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        tick;
        check("idle_start_busy", bus.busy, 0);
        check("idle_start_valid", bus.ki_valid, 0);
        run_full("key1", key_one, LZ ? 0 : 162, LZ ? 1 : 163, 164, 0);
        run_full("key0", key_zero, LZ ? -1 : 162, LZ ? 0 : 163, 164, 0);
        run_full("keya_load_ignored", key_a, 162, 163, LZ ? 165 : 164, 20);
        start_key(key_bp);
        wait_valid("bp");
        for (int j = 0; j < 3; j++) begin
            check("bp_ki", bus.ki, exp_bits[j]);
            check("bp_idx", bus.bit_idx, (LZ ? 2 : 162) - j);
            for (int g = 0; g < gaps[j]; g++) begin
                tick;
                check("bp_hold_ki", bus.ki, exp_bits[j]);
                check("bp_hold_idx", bus.bit_idx, (LZ ? 2 : 162) - j);
                check("bp_hold_valid", bus.ki_valid, 1);
                check("bp_hold_done", bus.done, 0);
            end
            bus.step_req = 1'b1;
            tick;
            bus.step_req = 1'b0;
        end
        check("bp_done_after_third", bus.done, LZ);
        check("bp_valid_after_third", bus.ki_valid, !LZ);
        bus.abort = 1'b1;
        tick;
        bus.abort = 1'b0;
        check("bp_clean_busy", bus.busy, 0);
        start_key(key_ones);
        wait_valid("abort_pre");
        bus.step_req = 1'b1;
        n = 0;
        while (bus.bit_idx != 80 && n < 400) begin
            tick;
            n++;
        end
        check("abort_reach_80", bus.bit_idx, 80);
        bus.step_req = 1'b0;
        bus.abort    = 1'b1;
        tick;
        bus.abort = 1'b0;
        check("abort_valid", bus.ki_valid, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_key_sr", dut.key_sr, 0);
        check("abort_remaining", dut.remaining, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("abort_no_done", bus.done, 0);
        end
        start_key(key_ones);
        wait_valid("restart");
        check("restart_idx", bus.bit_idx, 162);
        check("restart_ki", bus.ki, 1);
        bus.abort = 1'b1;
        tick;
        bus.abort  = 1'b0;
        bus.key_in = key_zero;
        bus.load   = 1'b1;
        tick;
        bus.key_in = key_top;
        bus.start  = 1'b1;
        tick;
        bus.load  = 1'b0;
        bus.start = 1'b0;
        check("ls_busy", bus.busy, 0);
        check("ls_valid", bus.ki_valid, 0);
        tick;
        check("ls_still_loaded", bus.busy, 0);
        bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        wait_valid("ls");
        check("ls_idx", bus.bit_idx, 162);
        check("ls_ki", bus.ki, 1);
        bus.step_req = 1'b1;
        tick;
        tick;
        check("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        bus.step_req = 1'b0;
        check("mid_rst_ki", bus.ki, 0);
        check("mid_rst_valid", bus.ki_valid, 0);
        check("mid_rst_last", bus.last_bit, 0);
        check("mid_rst_idx", bus.bit_idx, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_zero", bus.zero_key, 0);
        tick;
        check("post_rst_done", bus.done, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
